// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache and its refill controller.
// Both blocks decode addresses through the helpers below so they agree on
// which bits form the tag, index and word offset.
package cache_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int INDEX_W        = 4;

  // Derived geometry; not meant to be overridden independently.
  localparam int WOFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W  = ADDR_W - 2 - WOFF_W - INDEX_W;

  // Refill sequencing: wait for a miss, issue the burst, collect beats,
  // then a single completion cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  // Upper bits above index and word offset.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  // Line index sits just above the word offset.
  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[2+WOFF_W +: INDEX_W];
  endfunction

  // Word within the line; the two byte-offset bits are dropped.
  function automatic logic [WOFF_W-1:0] addr_woff(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WOFF_W];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss handler for the direct-mapped cache. Captures a missing address,
// issues one line-aligned burst read, writes each returned beat into the
// cache arrays, returns the originally requested word and pulses a
// line-complete strobe.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. miss_valid/miss_addr are held by the cache until miss_ready;
// mem_req_valid/mem_req_addr are held stable by this block until
// mem_req_ready. mem_rvalid has no back-pressure: every beat seen in FILL
// is consumed, beats seen in any other state are dropped.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                miss_ready,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fill_we,
  output logic [INDEX_W-1:0]  fill_index,
  output logic [WOFF_W-1:0]   fill_word,
  output logic [TAG_W-1:0]    fill_tag,
  output logic [DATA_W-1:0]   fill_data,
  output logic                fill_done,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic                busy,
  output refill_state_e       dbg_state
);

  localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS_PER_LINE - 1);
  localparam logic [WOFF_W-1:0] ONE_BEAT  = WOFF_W'(1);

  refill_state_e       state_q, state_d;
  logic [WOFF_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [WOFF_W-1:0]   woff_q, woff_d;
  logic                fill_we_q, fill_we_d;
  logic [WOFF_W-1:0]   fill_word_q, fill_word_d;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;

  // State, captured address, beat counter and registered fill/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tag_q       <= '0;
      index_q     <= '0;
      woff_q      <= '0;
      fill_we_q   <= 1'b0;
      fill_word_q <= '0;
      fill_data_q <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      index_q     <= index_d;
      woff_q      <= woff_d;
      fill_we_q   <= fill_we_d;
      fill_word_q <= fill_word_d;
      fill_data_q <= fill_data_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Next-state logic: miss capture, burst request, beat collection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    index_d     = index_q;
    woff_d      = woff_q;
    fill_we_d   = 1'b0;
    fill_word_d = fill_word_q;
    fill_data_d = fill_data_q;
    resp_data_d = resp_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          tag_d   = addr_tag(miss_addr);
          index_d = addr_index(miss_addr);
          woff_d  = addr_woff(miss_addr);
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        if (mem_rvalid) begin
          fill_we_d   = 1'b1;
          fill_word_d = cnt_q;
          fill_data_d = mem_rdata;
          if (cnt_q == woff_q) begin
            resp_data_d = mem_rdata;
          end
          // Counter wraps to zero on the last beat of the line.
          cnt_d = cnt_q + ONE_BEAT;
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // The final write is visible on the registered outputs this cycle.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign miss_ready    = (state_q == ST_IDLE);
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_addr  = {tag_q, index_q, {(WOFF_W + 2){1'b0}}};
  assign fill_we       = fill_we_q;
  assign fill_index    = index_q;
  assign fill_word     = fill_word_q;
  assign fill_tag      = tag_q;
  assign fill_data     = fill_data_q;
  assign fill_done     = (state_q == ST_DONE);
  assign resp_valid    = (state_q == ST_DONE);
  assign resp_data     = resp_data_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: table of refill scenarios with hand-computed
// address decodes, a scoreboard of expected fill writes and responses, and
// hand-written sequences for spurious beats, back-to-back misses and reset
// during a refill.
module tb_cache_refill_ctrl;

  logic                clk;
  logic                rst;
  logic                miss_valid;
  logic [31:0]         miss_addr;
  logic                miss_ready;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [31:0]         mem_req_addr;
  logic                mem_rvalid;
  logic [31:0]         mem_rdata;
  logic                fill_we;
  logic [3:0]          fill_index;
  logic [1:0]          fill_word;
  logic [23:0]         fill_tag;
  logic [31:0]         fill_data;
  logic                fill_done;
  logic                resp_valid;
  logic [31:0]         resp_data;
  logic                busy;
  cache_pkg::refill_state_e dbg_state;

  cache_refill_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .miss_valid    (miss_valid),
    .miss_addr     (miss_addr),
    .miss_ready    (miss_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .fill_we       (fill_we),
    .fill_index    (fill_index),
    .fill_word     (fill_word),
    .fill_tag      (fill_tag),
    .fill_data     (fill_data),
    .fill_done     (fill_done),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state: {index, tag, word, data} per expected write
  logic [61:0] exp_q[$];
  logic [31:0] resp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    int          stall;
    int          gap;
    logic [31:0] d0;
    logic [31:0] exp_req_addr;
    logic [3:0]  exp_index;
    logic [23:0] exp_tag;
    logic [31:0] exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every fill write and completion is matched against the queues
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (fill_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fill_we", {fill_index, fill_tag, fill_word, fill_data}, 64'h0);
        end else begin
          chk("fill_write", {fill_index, fill_tag, fill_word, fill_data}, exp_q.pop_front());
        end
      end
      if (fill_done || resp_valid) begin
        done_cnt++;
        chk("done_with_last_we", {fill_done, resp_valid, fill_we}, 3'b111);
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", resp_data, 64'h0);
        end else begin
          chk("resp_data", resp_data, resp_q.pop_front());
        end
      end
    end
  end

  // Driver for one complete refill; optionally keeps miss_valid asserted with
  // a following address so it is presented while the controller is busy.
  task automatic do_refill(input vec_t v, input bit hold_en, input logic [31:0] hold_addr);
    bit acc;
    int done_before;
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back({v.exp_index, v.exp_tag, 2'(w), v.d0 + 32'(w)});
    end
    resp_q.push_back(v.exp_resp);
    done_before = done_cnt;

    miss_valid = 1'b1;
    miss_addr  = v.addr;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (miss_ready) acc = 1'b1;
      tick();
    end
    chk("miss_accepted", acc, 1);
    if (hold_en) miss_addr = hold_addr;
    else miss_valid = 1'b0;

    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, v.exp_req_addr);
    chk("req_state", dbg_state, 1);
    chk("busy_req", {busy, miss_ready}, 2'b10);

    // Request stalls, with stray beats that must be ignored
    for (int i = 0; i < v.stall; i++) begin
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b1;
      mem_rdata     = 32'hDEAD_0000 | 32'(i);
      tick();
      chk("req_addr_stable", mem_req_addr, v.exp_req_addr);
      chk("req_valid_held", {mem_req_valid, fill_we, miss_ready}, 3'b100);
    end
    mem_rvalid    = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("fill_state", dbg_state, 2);

    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < v.gap; g++) begin
        tick();
        chk("miss_ready_gap", miss_ready, 0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = v.d0 + 32'(b);
      tick();
      mem_rvalid = 1'b0;
      chk("miss_ready_fill", miss_ready, 0);
    end
    chk("done_state", dbg_state, 3);
    tick();
    chk("miss_ready_after_done", {miss_ready, busy}, 2'b10);
    chk("all_words_written", exp_q.size(), 0);
    chk("one_done_pulse", done_cnt - done_before, 1);
  endtask

  initial begin
    int done_snap;

    //                addr          stall gap d0            req_addr      idx    tag           resp
    vecs[0] = '{32'h0000_0214, 0, 0, 32'h0000_00A0, 32'h0000_0210, 4'd1,  24'h000002, 32'h0000_00A1};
    vecs[1] = '{32'h0000_0014, 0, 0, 32'h0000_00B0, 32'h0000_0010, 4'd1,  24'h000000, 32'h0000_00B1};
    vecs[2] = '{32'h1234_5678, 5, 3, 32'h5A5A_00C0, 32'h1234_5670, 4'd7,  24'h123456, 32'h5A5A_00C2};
    vecs[3] = '{32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFD0, 32'hFFFF_FFF0, 4'd15, 24'hFFFFFF, 32'hFFFF_FFD3};
    vecs[4] = '{32'h0000_0003, 2, 0, 32'h0000_00E0, 32'h0000_0000, 4'd0,  24'h000000, 32'h0000_00E0};
    vecs[5] = '{32'h0000_0214, 0, 2, 32'h0000_0060, 32'h0000_0210, 4'd1,  24'h000002, 32'h0000_0061};

    // Reset state
    rst           = 1'b1;
    miss_valid    = 1'b0;
    miss_addr     = '0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    repeat (3) tick();
    chk("reset_ready", {miss_ready, busy, mem_req_valid}, 3'b100);
    chk("reset_strobes", {fill_we, fill_done, resp_valid}, 3'b000);
    chk("reset_addr", mem_req_addr, 0);
    chk("reset_data", {fill_data, resp_data}, 0);
    #3 rst = 1'b0;
    tick();

    // Spurious beats in IDLE
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_0000 | 32'(i);
      tick();
      chk("idle_beat_ignored", {fill_we, busy}, 2'b00);
    end
    mem_rvalid = 1'b0;

    // Table-driven refills; entry 2 holds the next miss while busy
    for (int i = 0; i < 5; i++) begin
      do_refill(vecs[i], (i == 2), vecs[3].addr);
    end

    // Reset in the middle of a refill
    for (int w = 0; w < 2; w++) begin
      exp_q.push_back({4'd1, 24'h000002, 2'(w), 32'h0000_0050 + 32'(w)});
    end
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0214;
    tick();
    miss_valid    = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_0050 + 32'(b);
      tick();
    end
    done_snap = done_cnt;
    #3 rst = 1'b1;
    #1;
    chk("midreset_ctrl", {miss_ready, busy, mem_req_valid, fill_we, fill_done, resp_valid}, 6'b100000);
    chk("midreset_addr", mem_req_addr, 0);
    chk("midreset_fill", {fill_index, fill_tag, fill_word}, 0);
    chk("midreset_data", {fill_data, resp_data}, 0);
    tick();
    tick();
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_beat_ignored", {fill_we, busy}, 2'b00);
    end
    mem_rvalid = 1'b0;
    chk("no_done_after_reset", done_cnt - done_snap, 0);
    chk("partial_words_seen", exp_q.size(), 0);
    do_refill(vecs[5], 1'b0, 32'h0);

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size() + resp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss handler sitting directly downstream of the direct-mapped cache.
- On a cache miss it accepts the missing address and fetches the whole line from backing memory with a single burst request.
- It writes each returned word into the cache data/tag arrays and pulses a line-complete strobe so the cache sets the valid bit.
- It also returns the originally requested word to the cache output path.

Parameters:
- ADDR_W, 32: address width in bits.
- DATA_W, 32: word width.
- WORDS_PER_LINE, 4: words per cache line; must be a power of 2 and ≥2.
- INDEX_W, 4: cache index bits (16 lines).
- Derived, not overridable:
  - WOFF_W = log2(WORDS_PER_LINE).
  - TAG_W = ADDR_W - 2 - WOFF_W - INDEX_W.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_valid  in  1  cache reports a miss.
- miss_addr  in  ADDR_W  byte address that missed.
- miss_ready  out  1  controller can accept a miss.
- mem_req_valid  out  1  burst read request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  line-aligned base address.
- mem_rvalid  in  1  one returned data beat.
- mem_rdata  in  DATA_W  beat data.
- fill_we  out  1  write strobe into cache arrays.
- fill_index  out  INDEX_W  line being filled.
- fill_word  out  WOFF_W  word within line.
- fill_tag  out  TAG_W  tag to store.
- fill_data  out  DATA_W  word to store.
- fill_done  out  1  one-cycle pulse: line complete, set valid.
- resp_valid  out  1  one-cycle pulse with resp_data.
- resp_data  out  DATA_W  word originally requested by miss_addr.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Address split of miss_addr:
  - bits[1:0] = byte offset (ignored).
  - next WOFF_W bits = word offset.
  - next INDEX_W bits = index.
  - remaining upper bits = tag.
- Reset (async, any time):
  - state = IDLE, beat counter = 0.
  - All outputs 0 except miss_ready = 1.
  - Captured address cleared.
- Reset mid-refill:
  - The partial line is abandoned.
  - fill_done never pulses for it.
  - Memory beats still arriving after reset are ignored.
- FSM states: IDLE, REQ, FILL, DONE.
  - IDLE:
    - miss_ready = 1.
    - On miss_valid & miss_ready, capture tag/index/word-offset and go to REQ.
    - mem_rvalid is ignored.
  - REQ:
    - mem_req_valid = 1.
    - mem_req_addr = {tag, index, WOFF_W+2 zero bits}, held stable until accepted.
    - On mem_req_ready, go to FILL with beat counter = 0.
    - Any mem_rvalid seen in REQ is ignored.
  - FILL:
    - Each mem_rvalid registers fill_we = 1 next cycle, with fill_word = counter, fill_data = mem_rdata, and fill_index/fill_tag from the captured address.
    - Counter then increments.
    - When the beat's counter equals the captured word offset, the data is also latched into resp_data.
    - Cycles without mem_rvalid produce fill_we = 0; gaps of any length are allowed.
    - On the beat with counter = WORDS_PER_LINE-1, go to DONE; the counter wraps to 0.
  - DONE (exactly one cycle):
    - The registered outputs show the final fill_we.
    - fill_done = 1 and resp_valid = 1 in the same cycle.
    - Then return to IDLE.
- Strobes: fill_we, fill_done and resp_valid are single-cycle and are never asserted outside the cases above.
- Latency:
  - Accept at cycle 0; mem_req_valid from cycle 1.
  - Each fill write appears one cycle after its mem_rvalid.
  - miss_ready returns the cycle after DONE.
- Concurrency: miss_valid while busy is not accepted (miss_ready = 0); the cache holds it.
- Fill words are written in ascending order 0..WORDS_PER_LINE-1. There is no critical-word-first ordering.

Decomposition:
- Shared package cache_pkg, containing:
  - ADDR_W, DATA_W, WORDS_PER_LINE, INDEX_W, and the derived WOFF_W and TAG_W;
  - the refill state enum;
  - functions addr_tag, addr_index and addr_woff.
- The cache block uses the same package so both blocks decode addresses identically.
- No sub-module: the address split is package functions, and the FSM with its counter is a single module.

Test Plan:
- Basic refill:
  - Stimulus: miss_addr = 0x0000_0214, mem_req_ready immediate, memory returns 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles.
  - Required: mem_req_addr = 0x0000_0210; fill_index = 1, fill_tag = 0x000002, fill_word = 0..3 with data 0xA0..0xA3; fill_done pulses with the 4th write; resp_data = 0xA1.
- Same index, different tag:
  - Stimulus: miss_addr = 0x0000_0014 after the basic refill.
  - Required: mem_req_addr = 0x0000_0010, fill_tag = 0, fill_index = 1.
- Stalls:
  - Stimulus: mem_req_ready held low for 5 cycles, then beats arriving with 3-cycle gaps.
  - Required: mem_req_addr stays stable while unaccepted; exactly 4 fill_we pulses; miss_ready stays 0 until after DONE.
- Back-to-back misses:
  - Stimulus: second miss_valid presented while busy.
  - Required: not accepted until miss_ready returns; then served normally.
- Spurious beats:
  - Stimulus: mem_rvalid pulsed in IDLE and in REQ.
  - Required: no fill_we, beat counter unchanged.
- Reset mid-refill:
  - Stimulus: rst asserted after 2 beats, mid-cycle.
  - Required: outputs clear immediately, fill_done never pulses, the next miss refills all 4 words from word 0.
